mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-ported, pipelined main memory between the I-cache miss
//  handler and the D-cache (miss fills plus write-through stores). Grants one
//  requester at a time, sequences block fills word-by-word, and returns fill
//  data tagged with word index and target cache.
//  Sits between the fetch/memory stages' caches and main memory. The pipeline
//  stalls on the caches' miss signals, so writeback never sees a partial fill.
// PARAMETERS
//  ADDR_W       16  byte-address width
//  DATA_W       16  word width
//  WORDS        8   words per cache block (power of 2, >=2)
//  MEM_LATENCY  4   cycles from read issue to mem_data_valid (>=1)
// PORTS
//  clk              in   1       clock; all state updates on rising edge
//  rst              in   1       reset, synchronous, active-high
//  icache_miss      in   1       I-cache requests a block fill (level, held until served)
//  icache_addr      in   ADDR_W  I-cache miss byte address
//  dcache_miss      in   1       D-cache requests a block fill (level)
//  dcache_addr      in   ADDR_W  D-cache miss byte address
//  dcache_wr        in   1       D-cache write-through store request (level)
//  dcache_wr_addr   in   ADDR_W  store byte address
//  dcache_wr_data   in   DATA_W  store data
//  dcache_wr_ack    out  1       1-cycle pulse: store issued to memory
//  mem_en           out  1       memory access this cycle
//  mem_wr           out  1       1 = write, 0 = read (valid when mem_en)
//  mem_addr         out  ADDR_W  memory byte address
//  mem_wdata        out  DATA_W  memory write data
//  mem_rdata        in   DATA_W  memory read data
//  mem_data_valid   in   1       mem_rdata valid (MEM_LATENCY after a read issue)
//  fill_valid       out  1       fill_data valid for fill_target
//  fill_target      out  1       0 = I-cache, 1 = D-cache
//  fill_word        out  clog2(WORDS)  word index within block of fill_data
//  fill_data        out  DATA_W  returned word
//  fill_done        out  1       1-cycle pulse: block for fill_target complete
//  busy             out  1       arbiter not in IDLE
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, counters=0; every output 0 from the first cycle after
//   rst is sampled high. Reset mid-fill aborts the fill silently. No fill_done.
//   mem_data_valid returning after reset is ignored, because IDLE ignores it.
//  States: IDLE, WRITE, FILL, DONE.
//  IDLE: pick one request by fixed priority dcache_wr > dcache_miss > icache_miss.
//   Latch the winning address, data and target. Go to WRITE or FILL next cycle.
//  WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr/mem_wdata = latched values.
//   dcache_wr_ack=1. Next state IDLE.
//  FILL: base = latched addr with the low clog2(2*WORDS) bits cleared.
//   Issue counter i=0..WORDS-1: mem_en=1, mem_wr=0, mem_addr=base+2*i,
//   one read per cycle for WORDS consecutive cycles; then mem_en=0.
//   Return counter r counts mem_data_valid. Each valid beat gives
//   fill_valid=1, fill_data=mem_rdata, fill_word=r (combinational passthrough).
//   Issue and return overlap.
//   When beat r=WORDS-1 is received, next state DONE.
//  DONE (1 cycle): fill_done=1, fill_target held. Next state IDLE.
//   The requester must drop its miss by the cycle after DONE (tag written on
//   the fill_done edge); IDLE then re-arbitrates.
//  Fill timing: first read issues in cycle 1 of FILL; last word returns
//   MEM_LATENCY+WORDS-1 cycles after that; fill_done is 1 cycle later.
//  Requests arriving during WRITE/FILL/DONE wait (level-held); no queuing.
//  Requests deasserted in IDLE before grant are dropped with no side effects.
//  Priority is strict: back-to-back stores delay fills (no fairness).
//  Address arithmetic wraps modulo 2^ADDR_W. The address is block-aligned,
//   so there is no carry out of the block.
//  busy=1 in WRITE, FILL, DONE. mem_wr=0 whenever mem_en=0.
// TESTING
//  1) I-miss alone, addr 0x1236 -> reads 0x1230,0x1232..0x123E on 8 consecutive
//     cycles; fill_word 0..7 with target 0; fill_done 1 cycle after word 7.
//  2) dcache_wr, icache_miss and dcache_miss all raised in the same cycle ->
//     WRITE first (ack once), then D fill, then I fill; never 2 grants at once.
//  3) Store 0xBEEF to 0x00A4 -> exactly one cycle with mem_en=1, mem_wr=1,
//     addr 0x00A4, data 0xBEEF, and dcache_wr_ack=1 in that cycle.
//  4) rst asserted at fill beat 3 -> next cycle all outputs 0, state IDLE;
//     stray mem_data_valid afterwards gives no fill_valid; re-request refills fully.
//  5) MEM_LATENCY=1 and MEM_LATENCY=6 -> correct word order/index, fill_done at
//     cycle MEM_LATENCY+WORDS+1 after grant; check address 0xFFF0 as fill base.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request/fill signals and memory bus of the memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
);
  localparam int WB = $clog2(WORDS);
  logic              icache_miss;
  logic [ADDR_W-1:0] icache_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_addr;
  logic              dcache_wr;
  logic [ADDR_W-1:0] dcache_wr_addr;
  logic [DATA_W-1:0] dcache_wr_data;
  logic              dcache_wr_ack;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_valid;
  logic              fill_valid;
  logic              fill_target;
  logic [WB-1:0]     fill_word;
  logic [DATA_W-1:0] fill_data;
  logic              fill_done;
  logic              busy;
  modport master (
    input  icache_miss, icache_addr, dcache_miss, dcache_addr, dcache_wr, dcache_wr_addr,
           dcache_wr_data, mem_rdata, mem_data_valid,
    output dcache_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_target,
           fill_word, fill_data, fill_done, busy
  );
  modport slave (
    output icache_miss, icache_addr, dcache_miss, dcache_addr, dcache_wr, dcache_wr_addr,
           dcache_wr_data, mem_rdata, mem_data_valid,
    input  dcache_wr_ack, mem_en, mem_wr, mem_addr, mem_wdata, fill_valid, fill_target,
           fill_word, fill_data, fill_done, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares pipelined main memory between I-cache fills, D-cache fills and D-cache stores.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WORDS       = 8,
  parameter int MEM_LATENCY = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);
  localparam int WB = $clog2(WORDS);
  localparam int OB = $clog2(2 * WORDS);
  if (WORDS < 2 || MEM_LATENCY < 1) begin : g_bad_params
    $error("mem_arbiter: WORDS must be >= 2 and MEM_LATENCY >= 1");
  end
  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, base;
  logic [DATA_W-1:0] wdata_q;
  logic              target_q;
  logic [WB:0]       issue;
  logic [WB-1:0]     ret;
  logic              issuing, beat;
  assign base = {addr_q[ADDR_W-1:OB], OB'(0)};
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      target_q <= 1'b0;
      issue    <= '0;
      ret      <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        addr_q   <= bus.dcache_wr ? bus.dcache_wr_addr : bus.dcache_miss ? bus.dcache_addr : bus.icache_addr;
        wdata_q  <= bus.dcache_wr_data;
        target_q <= bus.dcache_wr | bus.dcache_miss;
        issue    <= '0;
        ret      <= '0;
      end else if (state == FILL) begin
        if (!issue[WB]) issue <= issue + (WB+1)'(1);
        if (bus.mem_data_valid) ret <= ret + WB'(1);
      end
    end
  end
  // issue[WB] marks all WORDS reads sent; returns keep arriving while it is set
  always_comb begin
    issuing = state == FILL && !issue[WB];
    beat    = state == FILL && bus.mem_data_valid;
    state_n = state == IDLE  ? (bus.dcache_wr ? WRITE : (bus.dcache_miss | bus.icache_miss) ? FILL : IDLE)
            : state == WRITE ? IDLE
            : state == FILL  ? ((beat && &ret) ? DONE : FILL)
            : IDLE;
    bus.mem_en        = state == WRITE || issuing;
    bus.mem_wr        = state == WRITE;
    bus.mem_addr      = state == WRITE ? addr_q : issuing ? base + ADDR_W'({issue[WB-1:0], 1'b0}) : '0;
    bus.mem_wdata     = state == WRITE ? wdata_q : '0;
    bus.dcache_wr_ack = state == WRITE;
    bus.fill_valid    = beat;
    bus.fill_word     = beat ? ret : '0;
    bus.fill_data     = beat ? bus.mem_rdata : '0;
    bus.fill_target   = (state == FILL || state == DONE) && target_q;
    bus.fill_done     = state == DONE;
    bus.busy          = state != IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; three arbiters (latency 4, 1, 6) share stimulus, one is checked at a time.
module tb_mem_arbiter;
  typedef struct packed {
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        ack;
    logic        fill_valid;
    logic        fill_target;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        fill_done;
    logic        busy;
  } obs_t;
  typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] data;} mem_t;
  typedef struct packed {logic t; logic [2:0] w; logic [15:0] d;} beat_t;
  typedef struct packed {logic t; int cyc;} done_t;

  logic clk = 1'b0, rst;
  logic icache_miss, dcache_miss, dcache_wr;
  logic [15:0] icache_addr, dcache_addr, dcache_wr_addr, dcache_wr_data;
  obs_t [2:0] o;
  obs_t s;
  int sel = 0, cyc = 0, cmp = 0, err = 0;
  mem_t  mem_q[$];
  beat_t beat_q[$];
  done_t done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign s = o[sel];

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hA5C3;
  endfunction
  function automatic int lat(input int k);
    return k == 0 ? 4 : k == 1 ? 1 : 6;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = g == 0 ? 4 : g == 1 ? 1 : 6;
    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) bus ();
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .MEM_LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic        pv [L];
    logic [15:0] pd [L];
    initial for (int k = 0; k < L; k++) begin pv[k] = 1'b0; pd[k] = 16'h0; end
    always @(posedge clk) begin
      pv[0] <= bus.mem_en & ~bus.mem_wr;
      pd[0] <= mdata(bus.mem_addr);
      for (int k = 1; k < L; k++) begin pv[k] <= pv[k-1]; pd[k] <= pd[k-1]; end
    end
    assign bus.icache_miss    = icache_miss;
    assign bus.icache_addr    = icache_addr;
    assign bus.dcache_miss    = dcache_miss;
    assign bus.dcache_addr    = dcache_addr;
    assign bus.dcache_wr      = dcache_wr;
    assign bus.dcache_wr_addr = dcache_wr_addr;
    assign bus.dcache_wr_data = dcache_wr_data;
    assign bus.mem_rdata      = pd[L-1];
    assign bus.mem_data_valid = pv[L-1];
    assign o[g] = {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.dcache_wr_ack, bus.fill_valid,
                   bus.fill_target, bus.fill_word, bus.fill_data, bus.fill_done, bus.busy};
  end

  task automatic reset_all(input int k);
    sel = k;
    rst = 1'b1;
    {icache_miss, dcache_miss, dcache_wr} = '0;
    mem_q.delete(); beat_q.delete(); done_q.delete();
    repeat (8) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_fill(input logic t, input logic [15:0] a, input int g);
    logic [15:0] base = a & 16'hFFF0;
    logic [15:0] ad;
    for (int w = 0; w < 8; w++) begin
      ad = base + 16'(2 * w);
      mem_q.push_back('{1'b0, ad, 16'h0});
      beat_q.push_back('{t, 3'(w), mdata(ad)});
    end
    done_q.push_back('{t, g + lat(sel) + 9});
  endtask

  // consumes the expected queues as the checked arbiter produces bus and fill activity
  task automatic run(input int budget);
    int n = 0, last = -100;
    mem_t m; beat_t b; done_t d;
    forever begin
      @(negedge clk);
      n++;
      cmp++;
      if (s.mem_en) begin
        if (mem_q.size() == 0) begin
          err++; $display("FAIL mem_access: unexpected wr=%b addr=%h", s.mem_wr, s.mem_addr);
        end else begin
          m = mem_q.pop_front();
          if ({s.mem_wr, s.mem_addr, s.ack, s.mem_wr ? s.mem_wdata : 16'h0} !== {m.wr, m.addr, m.wr, m.data}) begin
            err++; $display("FAIL mem_access: got wr=%b addr=%h ack=%b wdata=%h, want wr=%b addr=%h ack=%b wdata=%h",
                            s.mem_wr, s.mem_addr, s.ack, s.mem_wdata, m.wr, m.addr, m.wr, m.data);
          end
        end
        if (s.ack) dcache_wr = 1'b0;
      end else if (s.mem_wr || s.ack) begin
        err++; $display("FAIL idle_bus: mem_wr=%b ack=%b with mem_en=0", s.mem_wr, s.ack);
      end
      if (s.fill_valid) begin
        cmp++;
        if (beat_q.size() == 0) begin
          err++; $display("FAIL fill_beat: unexpected word=%0d data=%h", s.fill_word, s.fill_data);
        end else begin
          b = beat_q.pop_front();
          if ({s.fill_target, s.fill_word, s.fill_data} !== {b.t, b.w, b.d}) begin
            err++; $display("FAIL fill_beat: got tgt=%b word=%0d data=%h, want tgt=%b word=%0d data=%h",
                            s.fill_target, s.fill_word, s.fill_data, b.t, b.w, b.d);
          end
        end
        last = cyc;
      end
      if (s.fill_done) begin
        cmp += 2;
        if (done_q.size() == 0) begin
          err++; $display("FAIL fill_done: unexpected pulse at cycle %0d", cyc);
        end else begin
          d = done_q.pop_front();
          if ({s.fill_target, cyc} !== {d.t, d.cyc}) begin
            err++; $display("FAIL fill_done: got tgt=%b cycle=%0d, want tgt=%b cycle=%0d", s.fill_target, cyc, d.t, d.cyc);
          end
          if (d.t) dcache_miss = 1'b0; else icache_miss = 1'b0;
        end
        if (cyc != last + 1) begin
          err++; $display("FAIL done_after_last: done at %0d, last word at %0d", cyc, last);
        end
      end
      if (!s.busy && mem_q.size() == 0 && beat_q.size() == 0 && done_q.size() == 0) break;
      if (n >= budget) begin
        err++;
        $display("FAIL run_timeout: %0d mem, %0d beats, %0d dones left", mem_q.size(), beat_q.size(), done_q.size());
        {icache_miss, dcache_miss, dcache_wr} = '0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    {icache_miss, dcache_miss, dcache_wr} = 3'b111;
    icache_addr = 16'h1111; dcache_addr = 16'h2222; dcache_wr_addr = 16'h3333; dcache_wr_data = 16'h4444;
    repeat (3) begin
      @(negedge clk);
      cmp++;
      if (s !== '0) begin err++; $display("FAIL reset_outputs: got %h want 0", s); end
    end
    reset_all(0);
  endtask

  task automatic test_ifill;
    reset_all(0);
    icache_addr = 16'h1236;
    icache_miss = 1'b1;
    push_fill(1'b0, 16'h1236, cyc);
    run(80);
  endtask

  task automatic test_store;
    reset_all(0);
    dcache_wr_addr = 16'h00A4;
    dcache_wr_data = 16'hBEEF;
    dcache_wr = 1'b1;
    mem_q.push_back('{1'b1, 16'h00A4, 16'hBEEF});
    run(20);
  endtask

  task automatic test_priority;
    int c0;
    reset_all(0);
    c0 = cyc;
    dcache_wr_addr = 16'h0310; dcache_wr_data = 16'h5A5A; dcache_addr = 16'h2468; icache_addr = 16'h1357;
    {icache_miss, dcache_miss, dcache_wr} = 3'b111;
    mem_q.push_back('{1'b1, 16'h0310, 16'h5A5A});
    push_fill(1'b1, 16'h2468, c0 + 2);
    push_fill(1'b0, 16'h1357, c0 + lat(0) + 12);
    run(120);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    reset_all(0);
    icache_addr = 16'h0040;
    icache_miss = 1'b1;
    do begin @(negedge clk); n++; end while (!(s.fill_valid && s.fill_word == 3'd3) && n < 40);
    cmp++;
    if (n >= 40) begin err++; $display("FAIL reach_beat3: no beat 3 within 40 cycles"); end
    rst = 1'b1;
    icache_miss = 1'b0;
    @(negedge clk);
    cmp++;
    if (s !== '0) begin err++; $display("FAIL reset_mid_fill: got %h want 0", s); end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      cmp++;
      if (s !== '0) begin err++; $display("FAIL stray_valid: got %h want 0", s); end
    end
    icache_miss = 1'b1;
    push_fill(1'b0, 16'h0040, cyc);
    run(80);
  endtask

  task automatic test_latency;
    for (int k = 1; k < 3; k++) begin
      reset_all(k);
      dcache_addr = 16'hFFFE;
      dcache_miss = 1'b1;
      push_fill(1'b1, 16'hFFFE, cyc);
      run(80);
      reset_all(k);
      icache_addr = 16'hFFF0;
      icache_miss = 1'b1;
      push_fill(1'b0, 16'hFFF0, cyc);
      run(80);
    end
  endtask

  initial begin
    rst = 1'b1;
    {icache_miss, dcache_miss, dcache_wr} = '0;
    {icache_addr, dcache_addr, dcache_wr_addr, dcache_wr_data} = '0;
    test_reset;
    test_ifill;
    test_store;
    test_priority;
    test_reset_mid;
    test_latency;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
